nird_frame_ctrl: RTL and testbench

- Frame sequencer for the R2 NI/RD datapath. It reads one frame from the original-image memory and the 3x3-median memory and streams both, pixel-locked, into the datapath's data/done inputs.
- It captures every {ni, rd} result into a result memory and signals frame completion with a start/busy/done handshake.
- A drain watchdog flags a datapath that never asserts its progress-done.

---
 rtl/nird_ctrl_pkg.sv | 27 ++
 rtl/nird_result_writer.sv | 84 ++++++++
 rtl/nird_frame_ctrl.sv | 145 ++++++++++++++
 tb/tb_nird_frame_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nird_ctrl_pkg.sv
// Shared types and sizing helpers for the NI/RD frame sequencer.
// Defaults describe a 30x30 frame.
package nird_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FEED,
      ST_DRAIN,
      ST_DONE
   } state_e;

   localparam int COLS_DEF     = 30;
   localparam int ROWS_DEF     = 30;
   localparam int FRAME_PIXELS = COLS_DEF * ROWS_DEF;

   function automatic int addr_bits(input int n);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/nird_result_writer.sv
// Captures {ni, rd} results into the result memory.
// The write pointer saturates on the last pixel; the count keeps going.
module nird_result_writer
   import nird_ctrl_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int NPIX   = FRAME_PIXELS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              capture_en_i,
   input  logic              res_done_i,
   input  logic [3:0]        ni_i,
   input  logic [3:0]        rd_i,
   output logic [ADDR_W-1:0] res_addr_o,
   output logic [7:0]        res_wdata_o,
   output logic              res_we_o,
   output logic [ADDR_W:0]   res_count_o
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);

   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              full_q, full_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              we_q, we_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;

   always_comb begin
      ptr_d   = ptr_q;
      full_d  = full_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;
      cnt_d   = cnt_q;
      if (clear_i) begin
         ptr_d  = '0;
         full_d = 1'b0;
         addr_d = '0;
         cnt_d  = '0;
      end else if (capture_en_i && res_done_i) begin
         if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
         end
         // Once the last address is written, later results are dropped.
         if (!full_q) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = {ni_i, rd_i};
            if (ptr_q == LAST) begin
               full_d = 1'b1;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= '0;
         full_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         ptr_q   <= ptr_d;
         full_q  <= full_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         cnt_q   <= cnt_d;
      end
   end

   assign res_addr_o  = addr_q;
   assign res_wdata_o = wdata_q;
   assign res_we_o    = we_q;
   assign res_count_o = cnt_q;

endmodule

// File: rtl/nird_frame_ctrl.sv
// Frame sequencer: streams one frame of original/median pixels into the
// NI/RD datapath, captures its results and watches for a stalled drain.
module nird_frame_ctrl
   import nird_ctrl_pkg::*;
#(
   parameter int COLS          = COLS_DEF,
   parameter int ROWS          = ROWS_DEF,
   parameter int ADDR_W        = addr_bits(COLS * ROWS),
   parameter int DRAIN_TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic              abort_i,
   output logic [ADDR_W-1:0] src_addr_o,
   output logic              src_rd_o,
   input  logic [7:0]        orig_q_i,
   input  logic [7:0]        med_q_i,
   output logic [7:0]        data_original_o,
   output logic              done_original_o,
   output logic [7:0]        m_3x3_o,
   output logic              done_m_3x3_o,
   input  logic [3:0]        ni_i,
   input  logic [3:0]        rd_i,
   input  logic              res_done_i,
   input  logic              res_progress_done_i,
   output logic [ADDR_W-1:0] res_addr_o,
   output logic [7:0]        res_wdata_o,
   output logic              res_we_o,
   output logic              busy_o,
   output logic              frame_done_o,
   output logic              timeout_o,
   output logic [ADDR_W:0]   res_count_o
);

   localparam int NPIX = COLS * ROWS;
   localparam int WD_W = $clog2(DRAIN_TIMEOUT + 1);

   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
   localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(DRAIN_TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pix_q, pix_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              to_q, to_d;
   logic              stb_q, stb_d;
   logic              clear;
   logic              cap_en;

   assign clear  = (state_q == ST_IDLE) && start_i && !abort_i;
   assign cap_en = ((state_q == ST_FEED) || (state_q == ST_DRAIN))
                   && !abort_i;

   always_comb begin
      state_d = state_q;
      pix_d   = pix_q;
      wd_d    = wd_q;
      to_d    = to_q;
      stb_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_FEED;
               pix_d   = '0;
               to_d    = 1'b0;
            end
         end
         ST_FEED: begin
            stb_d = 1'b1;
            if (pix_q == LAST_PIX) begin
               state_d = ST_DRAIN;
               wd_d    = '0;
            end else begin
               pix_d = pix_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            wd_d = wd_q + 1'b1;
            if (res_progress_done_i) begin
               state_d = ST_DONE;
            end else if (wd_q == WD_LAST) begin
               to_d    = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
      endcase
      // Abort overrides everything, including a start seen in IDLE.
      if (abort_i) begin
         state_d = ST_IDLE;
         pix_d   = pix_q;
         wd_d    = wd_q;
         to_d    = to_q;
         stb_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pix_q   <= '0;
         wd_q    <= '0;
         to_q    <= 1'b0;
         stb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pix_q   <= pix_d;
         wd_q    <= wd_d;
         to_q    <= to_d;
         stb_q   <= stb_d;
      end
   end

   // Source memories return data one cycle after the read, aligned
   // with the registered strobe.
   assign src_rd_o        = (state_q == ST_FEED);
   assign src_addr_o      = pix_q;
   assign done_original_o = stb_q;
   assign done_m_3x3_o    = stb_q;
   assign data_original_o = stb_q ? orig_q_i : 8'h00;
   assign m_3x3_o         = stb_q ? med_q_i : 8'h00;
   assign busy_o          = (state_q == ST_FEED) || (state_q == ST_DRAIN);
   assign frame_done_o    = (state_q == ST_DONE);
   assign timeout_o       = to_q;

   nird_result_writer #(
      .ADDR_W (ADDR_W),
      .NPIX   (NPIX)
   ) u_writer (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (clear),
      .capture_en_i (cap_en),
      .res_done_i   (res_done_i),
      .ni_i         (ni_i),
      .rd_i         (rd_i),
      .res_addr_o   (res_addr_o),
      .res_wdata_o  (res_wdata_o),
      .res_we_o     (res_we_o),
      .res_count_o  (res_count_o)
   );

endmodule

// File: tb/tb_nird_frame_ctrl.sv
// Directed/randomized bench for nird_frame_ctrl with memory and
// datapath models; results are checked against a sent-result queue.
module tb_nird_frame_ctrl;

   localparam int AW   = 10;
   localparam int NPIX = 900;
   localparam int TMO  = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic [AW-1:0] src_addr_o;
   logic          src_rd_o;
   logic [7:0]    orig_q = 8'h00;
   logic [7:0]    med_q = 8'h00;
   logic [7:0]    data_original_o;
   logic          done_original_o;
   logic [7:0]    m_3x3_o;
   logic          done_m_3x3_o;
   logic [3:0]    ni_i = 4'h0;
   logic [3:0]    rd_i = 4'h0;
   logic          res_done_i = 1'b0;
   logic          res_progress_done_i = 1'b0;
   logic [AW-1:0] res_addr_o;
   logic [7:0]    res_wdata_o;
   logic          res_we_o;
   logic          busy_o;
   logic          frame_done_o;
   logic          timeout_o;
   logic [AW:0]   res_count_o;

   nird_frame_ctrl #(
      .COLS          (30),
      .ROWS          (30),
      .ADDR_W        (AW),
      .DRAIN_TIMEOUT (TMO)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .start_i             (start_i),
      .abort_i             (abort_i),
      .src_addr_o          (src_addr_o),
      .src_rd_o            (src_rd_o),
      .orig_q_i            (orig_q),
      .med_q_i             (med_q),
      .data_original_o     (data_original_o),
      .done_original_o     (done_original_o),
      .m_3x3_o             (m_3x3_o),
      .done_m_3x3_o        (done_m_3x3_o),
      .ni_i                (ni_i),
      .rd_i                (rd_i),
      .res_done_i          (res_done_i),
      .res_progress_done_i (res_progress_done_i),
      .res_addr_o          (res_addr_o),
      .res_wdata_o         (res_wdata_o),
      .res_we_o            (res_we_o),
      .busy_o              (busy_o),
      .frame_done_o        (frame_done_o),
      .timeout_o           (timeout_o),
      .res_count_o         (res_count_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] orig_mem [0:1023];
   logic [7:0] med_mem  [0:1023];
   logic [7:0] res_mem  [0:1023];

   always @(posedge clk) begin
      if (src_rd_o) begin
         orig_q <= orig_mem[src_addr_o];
         med_q  <= med_mem[src_addr_o];
      end
   end

   int frame_id = 0;
   int seen_id = 0;
   int rd_cnt, first_rd, first_rd_addr, last_rd, seq_err;
   int stb_cnt, first_stb, last_stb, data_err;
   int wr_cnt, wr_addr_err, last_wr, max_wr_addr;
   int fd_cnt, fd_cyc, rd_at_fd, lastrd_at_fd, cnt_at_fd, to_at_fd, to_cyc;

   always @(negedge clk) begin
      if (frame_id != seen_id) begin
         seen_id = frame_id;
         rd_cnt = 0; first_rd = -1; first_rd_addr = -1; last_rd = -1;
         seq_err = 0; stb_cnt = 0; first_stb = -1; last_stb = -1;
         data_err = 0; wr_cnt = 0; wr_addr_err = 0; last_wr = -1;
         max_wr_addr = -1; fd_cnt = 0; fd_cyc = -1; rd_at_fd = -1;
         lastrd_at_fd = -1; cnt_at_fd = -1; to_at_fd = -1; to_cyc = -1;
      end
      if (!rst) begin
         if (src_rd_o) begin
            if (first_rd < 0) begin
               first_rd = cyc;
               first_rd_addr = int'(src_addr_o);
            end
            if (int'(src_addr_o) != rd_cnt % NPIX) seq_err++;
            rd_cnt++;
            last_rd = cyc;
         end
         if (done_original_o !== done_m_3x3_o) data_err++;
         if (done_original_o) begin
            if (first_stb < 0) first_stb = cyc;
            if (data_original_o !== orig_mem[stb_cnt % NPIX] ||
                m_3x3_o !== med_mem[stb_cnt % NPIX]) data_err++;
            stb_cnt++;
            last_stb = cyc;
         end
         if (res_we_o) begin
            if (int'(res_addr_o) != wr_cnt) wr_addr_err++;
            res_mem[res_addr_o] = res_wdata_o;
            if (int'(res_addr_o) > max_wr_addr) max_wr_addr = int'(res_addr_o);
            wr_cnt++;
            last_wr = cyc;
         end
         if (frame_done_o) begin
            fd_cnt++;
            fd_cyc = cyc;
            rd_at_fd = rd_cnt;
            lastrd_at_fd = last_rd;
            cnt_at_fd = int'(res_count_o);
            to_at_fd = int'(timeout_o);
         end
         if (timeout_o && to_cyc < 0) to_cyc = cyc;
      end
   end

   int tests = 0;
   int fails = 0;
   int t0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic begin_frame();
      frame_id++;
      start_i = 1'b1;
      t0 = cyc;
      tick();
      start_i = 1'b0;
   endtask

   // prog: 1 = progress-done after last result, 2 = with last result
   task automatic run_frame(input int n, input int prog, input int gaps,
                            input int fs, input bit done_start);
      logic [7:0] sent [$];
      int g;
      int exp_w;
      int mism;
      g = 0;
      begin_frame();
      tick();
      for (int i = 0; i < n; i++) begin
         if (g < gaps && $urandom_range(0, 63) == 0) begin
            res_done_i = 1'b0;
            start_i = 1'b0;
            tick();
            g++;
         end
         start_i = (i == fs);
         res_done_i = 1'b1;
         ni_i = 4'($urandom);
         rd_i = 4'($urandom);
         sent.push_back({ni_i, rd_i});
         res_progress_done_i = (prog == 2) && (i == n - 1);
         tick();
      end
      res_done_i = 1'b0;
      start_i = 1'b0;
      res_progress_done_i = 1'b0;
      if (prog == 1) begin
         res_progress_done_i = 1'b1;
         tick();
         res_progress_done_i = 1'b0;
      end
      if (done_start) begin
         chk("done_cycle", frame_done_o, 1);
         chk("count_at_done", res_count_o, n);
         start_i = 1'b1;
         tick();
         start_i = 1'b0;
         chk("start_in_done_ignored", busy_o, 0);
         start_i = 1'b1;
         tick();
         start_i = 1'b0;
         chk("start_after_done", {busy_o, src_rd_o, src_addr_o},
             {1'b1, 1'b1, 10'd0});
         abort_i = 1'b1;
         tick();
         abort_i = 1'b0;
         chk("abort_after_restart", busy_o, 0);
      end
      for (int k = 0; k < 40 && fd_cnt == 0; k++) tick();
      repeat (3) tick();
      exp_w = (n < NPIX) ? n : NPIX;
      mism = 0;
      for (int i = 0; i < exp_w; i++) begin
         if (res_mem[i] !== sent[i]) mism++;
      end
      chk("first_rd_cycle", first_rd, t0 + 1);
      chk("first_rd_addr", first_rd_addr, 0);
      chk("rd_count", rd_at_fd, NPIX);
      chk("last_rd_cycle", lastrd_at_fd, t0 + NPIX);
      chk("src_addr_seq", seq_err, 0);
      chk("first_stb_cycle", first_stb, t0 + 2);
      chk("stb_count", stb_cnt, NPIX);
      chk("last_stb_cycle", last_stb, t0 + NPIX + 1);
      chk("pixel_data", data_err, 0);
      chk("write_count", wr_cnt, exp_w);
      chk("write_addr_seq", wr_addr_err, 0);
      chk("last_write_addr", max_wr_addr, exp_w - 1);
      chk("result_contents", mism, 0);
      chk("frame_done_pulses", fd_cnt, 1);
      chk("res_count_at_done", cnt_at_fd, n);
      chk("no_timeout", to_at_fd, 0);
      chk("write_before_done", (last_wr <= fd_cyc), 1);
   endtask

   int nres;

   initial begin
      for (int i = 0; i < 1024; i++) begin
         orig_mem[i] = 8'($urandom);
         med_mem[i]  = 8'($urandom);
      end
      repeat (3) tick();
      chk("reset_outputs",
          {src_addr_o, src_rd_o, data_original_o, done_original_o, m_3x3_o,
           done_m_3x3_o, res_addr_o, res_wdata_o, res_we_o, busy_o,
           frame_done_o, timeout_o, res_count_o}, 64'd0);
      rst = 1'b0;
      tick();

      begin_frame();
      for (int k = 0; k < 1000 && src_addr_o != 10'd400; k++) tick();
      chk("mid_feed_addr", src_addr_o, 400);
      #2 rst = 1'b1;
      #1;
      chk("async_reset_outputs",
          {src_addr_o, src_rd_o, data_original_o, done_original_o, m_3x3_o,
           done_m_3x3_o, res_addr_o, res_wdata_o, res_we_o, busy_o,
           frame_done_o, timeout_o, res_count_o}, 64'd0);
      tick();
      rst = 1'b0;
      tick();

      run_frame(900, 1, 4, 300, 1'b0);
      run_frame(900, 2, 0, -1, 1'b1);
      run_frame(905, 1, 3, -1, 1'b0);

      begin_frame();
      for (int k = 0; k < 1200 && fd_cnt == 0; k++) tick();
      chk("wd_done_cycle", fd_cyc, t0 + NPIX + 1 + TMO);
      chk("wd_timeout_cycle", to_cyc, t0 + NPIX + 1 + TMO);
      chk("wd_timeout_sticky", timeout_o, 1);
      chk("wd_res_count", res_count_o, 0);

      begin_frame();
      chk("timeout_cleared", timeout_o, 0);
      nres = 0;
      for (int k = 0; k < 200 && src_addr_o != 10'd100; k++) begin
         res_done_i = (nres < 50);
         ni_i = 4'($urandom);
         rd_i = 4'($urandom);
         if (res_done_i) nres++;
         tick();
      end
      res_done_i = 1'b0;
      chk("abort_at_pixel", src_addr_o, 100);
      abort_i = 1'b1;
      start_i = 1'b1;
      tick();
      abort_i = 1'b0;
      start_i = 1'b0;
      chk("abort_idle",
          {busy_o, src_rd_o, done_original_o, done_m_3x3_o, res_we_o}, 0);
      repeat (3) tick();
      chk("abort_stays_idle", busy_o, 0);
      chk("abort_no_frame_done", fd_cnt, 0);
      chk("abort_count_held", res_count_o, nres);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
